// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding and sample width for the I2S capture path
package i2s_pkg;
  localparam int I2S_SAMPLE_W = 24;
  typedef enum logic [1:0] {ST_IDLE, ST_RST, ST_SETTLE, ST_CAPTURE} state_t;
endpackage

// File: rtl/i2s_out_reg.sv
// i2s_out_reg: single-entry valid/ready holding register with load/drop decisions
module i2s_out_reg import i2s_pkg::*; #(
  parameter int OUT_W = 18
) (
  input  logic                    i2s_clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    sample_valid,
  input  logic [I2S_SAMPLE_W-1:0] sample,
  input  logic                    last,
  input  logic                    m_ready,
  output logic [OUT_W-1:0]        m_data,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    load,
  output logic                    drop
);
  logic full;
  assign full = m_valid && !m_ready;
  assign load = en && sample_valid && !full;
  assign drop = en && sample_valid && full;
  always_ff @(posedge i2s_clk or negedge reset_n)
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= sample[I2S_SAMPLE_W-1 -: OUT_W];
      m_last  <= last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
endmodule

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: sequences the I2S receiver and frames its samples onto a valid/ready stream
module i2s_capture_ctrl import i2s_pkg::*; #(
  parameter int FRAME_LEN       = 1024,
  parameter int OUT_W           = 18,
  parameter int RST_CYCLES      = 4,
  parameter int DISCARD_SAMPLES = 2,
  parameter int FC_W            = 16
) (
  input  logic                    i2s_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  output logic                    rx_reset,
  input  logic [I2S_SAMPLE_W-1:0] rx_sample,
  input  logic                    rx_sample_valid,
  output logic [OUT_W-1:0]        m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              overrun_count,
  output logic [FC_W-1:0]         frame_count
);
  localparam int IW = $clog2(FRAME_LEN);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int DW = $clog2(DISCARD_SAMPLES + 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] DISC_LAST = DW'(DISCARD_SAMPLES == 0 ? 0 : DISCARD_SAMPLES - 1);
  state_t          state;
  logic            cont, stop_pending, en, load, drop, frame_done;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   rst_cnt;
  logic [DW-1:0]   disc_cnt;
  // once a frame-ending beat is held, further strobes are ignored unless the next frame follows
  assign en = state == ST_CAPTURE && !(m_valid && m_last && (!cont || stop_pending));
  assign frame_done = m_valid && m_ready && m_last;
  i2s_out_reg #(.OUT_W(OUT_W)) u_out (
    .i2s_clk(i2s_clk), .reset_n(reset_n), .en(en), .sample_valid(rx_sample_valid),
    .sample(rx_sample), .last(idx == IDX_LAST), .m_ready(m_ready), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .load(load), .drop(drop)
  );
  always_ff @(posedge i2s_clk or negedge reset_n)
    if (!reset_n) begin
      state         <= ST_IDLE;
      rx_reset      <= 1'b1;
      busy          <= 1'b0;
      cont          <= 1'b0;
      stop_pending  <= 1'b0;
      idx           <= '0;
      rst_cnt       <= '0;
      disc_cnt      <= '0;
      overrun       <= 1'b0;
      overrun_count <= '0;
      frame_count   <= '0;
    end else begin
      if (load) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_count != 8'hff) overrun_count <= overrun_count + 8'd1;
      end
      if (frame_done) frame_count <= frame_count + 1'b1;
      case (state)
        ST_IDLE:
          if (start && !stop) begin
            state         <= ST_RST;
            busy          <= 1'b1;
            cont          <= continuous;
            overrun       <= 1'b0;
            overrun_count <= '0;
            rst_cnt       <= RST_LAST;
            idx           <= '0;
          end
        ST_RST:
          if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else if (rst_cnt == '0) begin
            state    <= DISCARD_SAMPLES == 0 ? ST_CAPTURE : ST_SETTLE;
            rx_reset <= 1'b0;
            disc_cnt <= '0;
          end else rst_cnt <= rst_cnt - 1'b1;
        ST_SETTLE:
          if (stop) begin
            state    <= ST_IDLE;
            rx_reset <= 1'b1;
            busy     <= 1'b0;
          end else if (rx_sample_valid) begin
            if (disc_cnt == DISC_LAST) state <= ST_CAPTURE;
            else disc_cnt <= disc_cnt + 1'b1;
          end
        ST_CAPTURE: begin
          if (stop) stop_pending <= 1'b1;
          if (frame_done && (!cont || stop_pending)) begin
            state        <= ST_IDLE;
            rx_reset     <= 1'b1;
            busy         <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
